// File: rtl/fft_twiddle_gen.sv
// fft_twiddle_gen: pipelined twiddle-factor generator for radix-2 FFT stages.
// Returns W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), with k = (addr << stage) mod N.
// Values come from a quarter-wave sine ROM using quadrant folding.
// The latency is three cycles. An optional conjugate is applied for IFFT use.
module fft_twiddle_gen #(
    parameter int N_LOG2 = 4,
    parameter int DW     = 12,
    parameter int SW     = $clog2(N_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [N_LOG2-1:0]    addr,
    input  logic [SW-1:0]        stage,
    input  logic                 inverse,
    output logic signed [DW-1:0] twiddle_re,
    output logic signed [DW-1:0] twiddle_im,
    output logic                 valid_out
);

    localparam int     QUARTER = 1 << (N_LOG2 - 2);     // N/4
    localparam int     AW      = N_LOG2 - 1;            // index width covering 0..N/4
    localparam int     MW      = DW - 1;                // unsigned magnitude width
    localparam longint AMP     = (longint'(1) << (DW - 1)) - 1;

    // round(AMP * sin(pi*i / (2*QUARTER))), evaluated at elaboration via a Taylor series
    function automatic logic [MW-1:0] rom_entry(input int i);
        real    x;
        real    term;
        real    sum;
        longint v;
        x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(QUARTER));
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        v = longint'(real'(AMP) * sum);
        if (v > AMP) v = AMP;
        if (v < 0)   v = 0;
        return MW'(v);
    endfunction

    // NOTE: the ROM is a constant table, not state, so it has no reset and no write port.
    logic [MW-1:0] rom [0:QUARTER];
    for (genvar gi = 0; gi <= QUARTER; gi++) begin : g_rom
        localparam logic [MW-1:0] VAL = rom_entry(gi);
        assign rom[gi] = VAL;
    end

    // ---------------- P1: index folding ----------------
    logic [N_LOG2-1:0] k_in;
    logic [AW-1:0]     r_in;
    logic [AW-1:0]     cr_in;

    // Effective index and its quarter-wave offsets; the shift truncates to give mod N
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        k_in  = addr << stage;
        r_in  = AW'(k_in & N_LOG2'(QUARTER - 1));
        cr_in = AW'(QUARTER) - r_in;
    end

    logic              v_p1;
    logic [N_LOG2-1:0] k_p1;
    logic [AW-1:0]     cr_p1;
    logic              inv_p1;

    // P1 register: accept the request; inverse and stage matter only when valid is 1
    // NOTE: sequential state uses non-blocking assignments, so stages update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_p1   <= 1'b0;
            k_p1   <= '0;
            cr_p1  <= '0;
            inv_p1 <= 1'b0;
        end else begin
            v_p1 <= valid;
            if (valid) begin
                k_p1   <= k_in;
                cr_p1  <= cr_in;
                inv_p1 <= inverse;
            end
        end
    end

    // The quadrant and the in-quadrant offset are bit fields of the registered k
    logic [1:0]    q_p1;
    logic [AW-1:0] r_p1;
    assign q_p1 = k_p1[N_LOG2-1 -: 2];
    assign r_p1 = AW'(k_p1 & N_LOG2'(QUARTER - 1));

    // ---------------- P2: ROM reads ----------------
    logic          v_p2;
    logic [MW-1:0] s_p2;
    logic [MW-1:0] c_p2;
    logic [1:0]    q_p2;
    logic          inv_p2;

    // P2 register: capture the sine (s) and cosine (c) magnitudes for this quadrant offset
    always_ff @(posedge clk) begin
        if (rst) begin
            v_p2   <= 1'b0;
            s_p2   <= '0;
            c_p2   <= '0;
            q_p2   <= '0;
            inv_p2 <= 1'b0;
        end else begin
            v_p2 <= v_p1;
            if (v_p1) begin
                s_p2   <= rom[r_p1];
                c_p2   <= rom[cr_p1];
                q_p2   <= q_p1;
                inv_p2 <= inv_p1;
            end
        end
    end

    // ---------------- P3: sign/swap and outputs ----------------
    logic signed [DW-1:0] s_ext;
    logic signed [DW-1:0] c_ext;
    logic signed [DW-1:0] re_nxt;
    logic signed [DW-1:0] im_nxt;

    // Quadrant mapping, then conjugation on inverse; magnitudes <= AMP, so negation is safe
    always_comb begin
        s_ext  = signed'({1'b0, s_p2});
        c_ext  = signed'({1'b0, c_p2});
        re_nxt = c_ext;
        im_nxt = -s_ext;
        case (q_p2)
            2'd0: begin re_nxt = c_ext;  im_nxt = -s_ext; end
            2'd1: begin re_nxt = -s_ext; im_nxt = -c_ext; end
            2'd2: begin re_nxt = -c_ext; im_nxt = s_ext;  end
            default: begin re_nxt = s_ext; im_nxt = c_ext; end
        endcase
        if (inv_p2) im_nxt = -im_nxt;
    end

    // Output register: load on a valid result and hold the last value otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            twiddle_re <= '0;
            twiddle_im <= '0;
        end else begin
            valid_out <= v_p2;
            if (v_p2) begin
                twiddle_re <= re_nxt;
                twiddle_im <= im_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// tb_fft_twiddle_gen: self-checking bench for fft_twiddle_gen (N = 16, DW = 12).
// A scoreboard queue holds each expected result and the cycle at which it is due.
module tb_fft_twiddle_gen;

    localparam int N_LOG2 = 4;
    localparam int DW     = 12;
    localparam int SW     = 2;
    localparam int A      = 2047;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic [N_LOG2-1:0]    addr;
    logic [SW-1:0]        stage;
    logic                 inverse;
    logic signed [DW-1:0] twiddle_re;
    logic signed [DW-1:0] twiddle_im;
    logic                 valid_out;

    fft_twiddle_gen #(.N_LOG2(N_LOG2), .DW(DW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .addr       (addr),
        .stage      (stage),
        .inverse    (inverse),
        .twiddle_re (twiddle_re),
        .twiddle_im (twiddle_im),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int re;
        int im;
        int tol;
        int due;
    } exp_t;

    typedef struct {
        logic [N_LOG2-1:0] addr;
        logic [SW-1:0]     stage;
        logic              inv;
        int                re;
        int                im;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   hold_re  = 0;
    int   hold_im  = 0;
    int   hold_tol = 0;
    int   next_id  = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit near(input int a, input int e, input int tol);
        return (a >= e - tol) && (a <= e + tol);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Compare DUT outputs against the scoreboard, once per cycle, 1 time unit after the edge
    task automatic monitor();
        exp_t e;
        int   re_a;
        int   im_a;
        re_a = int'(twiddle_re);
        im_a = int'(twiddle_im);
        if (valid_out) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected valid_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check(cyc == e.due, $sformatf("latency id%0d", e.id), cyc, e.due);
                check(near(re_a, e.re, e.tol), $sformatf("re id%0d", e.id), re_a, e.re);
                check(near(im_a, e.im, e.tol), $sformatf("im id%0d", e.id), im_a, e.im);
                check(iabs(re_a) <= A, $sformatf("range re id%0d", e.id), re_a, A);
                check(iabs(im_a) <= A, $sformatf("range im id%0d", e.id), im_a, A);
                hold_re  = e.re;
                hold_im  = e.im;
                hold_tol = e.tol;
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check(1'b0, $sformatf("missing output id%0d", e.id), cyc, e.due);
            end
            check(near(re_a, hold_re, hold_tol), "hold re", re_a, hold_re);
            check(near(im_a, hold_im, hold_tol), "hold im", im_a, hold_im);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    // Drive one cycle of stimulus; a valid request pushes its expectation, due 3 cycles later
    task automatic drive(input bit v, input logic [N_LOG2-1:0] a, input logic [SW-1:0] s,
                         input bit inv, input int re, input int im, input int tol);
        valid   = v;
        addr    = a;
        stage   = s;
        inverse = inv;
        if (v) begin
            sb.push_back('{next_id, re, im, tol, cyc + 3});
            next_id++;
        end
        tick();
    endtask

    // Idle cycles with random stage/inverse/addr, which must all be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, N_LOG2'($urandom), SW'($urandom), 1'($urandom), 0, 0, 0);
    endtask

    // One reset cycle, optionally with a simultaneous request that must be dropped
    task automatic do_reset(input bit v);
        rst     = 1'b1;
        valid   = v;
        addr    = 4'd3;
        stage   = 2'd0;
        inverse = 1'b0;
        sb.delete();
        hold_re  = 0;
        hold_im  = 0;
        hold_tol = 0;
        tick();
        check(valid_out == 1'b0, "reset valid_out", int'(valid_out), 0);
        check(twiddle_re == '0, "reset re", int'(twiddle_re), 0);
        check(twiddle_im == '0, "reset im", int'(twiddle_im), 0);
        rst   = 1'b0;
        valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        real pi;
        real ang;
        pi = 3.14159265358979323846;

        vecs[0]  = '{4'd0,  2'd0, 1'b0,  2047,     0};
        vecs[1]  = '{4'd2,  2'd0, 1'b0,  1447, -1447};
        vecs[2]  = '{4'd4,  2'd0, 1'b0,     0, -2047};
        vecs[3]  = '{4'd6,  2'd0, 1'b0, -1447, -1447};
        vecs[4]  = '{4'd12, 2'd0, 1'b0,     0,  2047};
        vecs[5]  = '{4'd1,  2'd0, 1'b0,  1891,  -783};
        vecs[6]  = '{4'd4,  2'd0, 1'b1,     0,  2047};
        vecs[7]  = '{4'd1,  2'd0, 1'b1,  1891,   783};
        vecs[8]  = '{4'd1,  2'd2, 1'b0,     0, -2047};
        vecs[9]  = '{4'd5,  2'd2, 1'b0,     0, -2047};
        vecs[10] = '{4'd3,  2'd3, 1'b0, -2047,     0};
        vecs[11] = '{4'd9,  2'd0, 1'b1, -1891,  -783};

        // Reset state
        valid   = 1'b0;
        addr    = '0;
        stage   = '0;
        inverse = 1'b0;
        do_reset(1'b0);
        idle(2);

        // Isolated single requests
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].addr, vecs[i].stage, vecs[i].inv, vecs[i].re, vecs[i].im, 0);
            idle(3);
        end

        // Inverse, stride and wrap-around cases, back to back
        for (int i = 6; i < 12; i++)
            drive(1'b1, vecs[i].addr, vecs[i].stage, vecs[i].inv, vecs[i].re, vecs[i].im, 0);
        idle(4);

        // Full stream against a floating-point model, within 1 LSB
        for (int k = 0; k < 16; k++) begin
            ang = 2.0 * pi * real'(k) / 16.0;
            drive(1'b1, N_LOG2'(k), 2'd0, 1'b0,
                  rnd(real'(A) * $cos(ang)), -rnd(real'(A) * $sin(ang)), 1);
        end
        idle(4);

        // Bubbles: valid 1,0,0,1 and the outputs hold the first result through the gap
        drive(1'b1, 4'd2, 2'd0, 1'b0, 1447, -1447, 0);
        idle(2);
        drive(1'b1, 4'd6, 2'd0, 1'b0, -1447, -1447, 0);
        idle(5);

        // Reset mid-stream: two requests in flight, plus a third presented with rst, all flushed
        drive(1'b1, 4'd1, 2'd0, 1'b0, 1891, -783, 0);
        drive(1'b1, 4'd2, 2'd0, 1'b0, 1447, -1447, 0);
        do_reset(1'b1);
        drive(1'b1, 4'd12, 2'd0, 1'b0, 0, 2047, 0);
        idle(6);

        check(sb.size() == 0, "scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
